// File: rtl/mbist_pkg.sv
// mbist_pkg: shared types and March C- element tables for the MBIST sequencer.
//   march_elem_e : march element index M0..M5
//   op_e         : memory operation (read / write)
//   state_e      : controller state encoding
//   elem_*       : per-element direction, op count and read/write data polarity
package mbist_pkg;

   typedef enum logic [2:0] {M0 = 3'd0, M1, M2, M3, M4, M5} march_elem_e;
   typedef enum logic {OP_R = 1'b0, OP_W = 1'b1} op_e;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_e;

   // March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 dn(r0,w1); M4 dn(r1,w0); M5 up(r0)
   function automatic logic elem_down(input march_elem_e e);
      return (e == M3) || (e == M4);
   endfunction

   function automatic logic [1:0] elem_nops(input march_elem_e e);
      return ((e == M0) || (e == M5)) ? 2'd1 : 2'd2;
   endfunction

   // 1 = the element reads/writes the inverted background
   function automatic logic elem_rpol(input march_elem_e e);
      return (e == M2) || (e == M4);
   endfunction

   function automatic logic elem_wpol(input march_elem_e e);
      return (e == M1) || (e == M3);
   endfunction

   // Two-op elements always read first, then write the same address.
   function automatic op_e elem_op(input march_elem_e e, input logic phase);
      if (e == M0) return OP_W;
      if (e == M5) return OP_R;
      return phase ? OP_W : OP_R;
   endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: march address counter.
//   clk, rst   : clock, async active-high reset (address returns to 0)
//   load       : load the start address of the next element
//   load_down  : direction of the element being loaded (1 -> start at N-1)
//   step       : advance one address in direction 'down'
//   down       : direction of the current element
//   addr       : current address
//   last       : current address is the terminal one for 'down'
module mbist_addr_gen #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              load_down,
   input  logic              step,
   input  logic              down,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       addr <= '0;
      else if (load) addr <= load_down ? {ADDR_W{1'b1}} : '0;
      else if (step) addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
   end

   // Element ends on the terminal address; the counter itself never wraps.
   assign last = down ? (addr == '0) : (addr == {ADDR_W{1'b1}});

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST sequencer for one single-port SRAM.
//   clk, rst        : clock, async active-high reset
//   start           : begin a test (level-sampled in IDLE/DONE only)
//   mem_ceb/web/a/d : registered SRAM controls (ceb, web active low)
//   mem_q           : SRAM read data, valid the cycle after a read is on the pins
//   busy, done      : test in progress / test complete (held until next start)
//   pass            : valid with done; 1 = no mismatching reads
//   fail_count      : saturating mismatch count
//   fail_addr/elem/data : address, element and read data of the first mismatch
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int                ADDR_W = 5,
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] BG     = '0,
   parameter int                CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_ceb,
   output logic              mem_web,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_d,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  fail_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_data
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_FLUSH = FLUSH;
   localparam logic [1:0] S_DONE  = DONE;
   // read on pins -> data out of macro -> compare
   localparam int STAGES = 1;

   logic [1:0]        state;
   march_elem_e       elem;
   logic              phase;
   logic              ops_done;
   logic [ADDR_W-1:0] addr;
   logic              addr_last;

   logic              start_acc, launch, last_ph, elem_end;
   op_e               cur_op;
   march_elem_e       elem_nxt;
   logic [DATA_W-1:0] wdat, rexp;

   // Sequence counters always point at the next op to issue; between tests
   // they rest at M0/phase 0/address 0 so the start edge can issue op 1.
   assign start_acc = ((state == S_IDLE) || (state == S_DONE)) && start;
   assign launch    = start_acc || ((state == S_RUN) && !ops_done);
   assign cur_op    = elem_op(elem, phase);
   assign last_ph   = (elem_nops(elem) == 2'd1) || phase;
   assign elem_end  = last_ph && addr_last;
   assign elem_nxt  = (elem == M5) ? M0 : march_elem_e'(elem + 3'd1);
   assign wdat      = elem_wpol(elem) ? ~BG : BG;
   assign rexp      = elem_rpol(elem) ? ~BG : BG;

   mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
      .clk       (clk),
      .rst       (rst),
      .load      (launch && elem_end),
      .load_down (elem_down(elem_nxt)),
      .step      (launch && last_ph && !addr_last),
      .down      (elem_down(elem)),
      .addr      (addr),
      .last      (addr_last)
   );

   // ---------------- sequencer / FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         elem     <= M0;
         phase    <= 1'b0;
         ops_done <= 1'b0;
         mem_ceb  <= 1'b1;
         mem_web  <= 1'b1;
         mem_a    <= '0;
         mem_d    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (launch) begin
            mem_ceb <= 1'b0;
            mem_web <= (cur_op == OP_R);
            mem_a   <= addr;
            mem_d   <= (cur_op == OP_W) ? wdat : '0;
            if (!last_ph) begin
               phase <= 1'b1;
            end else begin
               phase <= 1'b0;
               if (addr_last) begin
                  elem <= elem_nxt;
                  // last op of M5: counters already reloaded to M0 above
                  if (elem == M5) ops_done <= 1'b1;
               end
            end
         end else begin
            mem_ceb <= 1'b1;
            mem_web <= 1'b1;
            mem_d   <= '0;
         end

         case (state)
            S_IDLE, S_DONE: if (start) begin
               state <= S_RUN;
               busy  <= 1'b1;
               done  <= 1'b0;
            end
            S_RUN: if (ops_done) begin
               state    <= S_FLUSH;
               ops_done <= 1'b0;
            end
            S_FLUSH: begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------- expected-data pipeline and fail capture ----------------
   logic [STAGES:0]                   vld_pipe;
   logic [STAGES:0][DATA_W-1:0]       exp_pipe;
   logic [STAGES:0][ADDR_W-1:0]       addr_pipe;
   logic [STAGES:0][2:0]              elem_pipe;
   logic                              mismatch;
   logic [CNT_W-1:0]                  cnt_nxt;

   assign mismatch = vld_pipe[STAGES] && (mem_q != exp_pipe[STAGES]);
   assign cnt_nxt  = (mismatch && (fail_count != {CNT_W{1'b1}})) ?
                     fail_count + CNT_W'(1) : fail_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe   <= '0;
         exp_pipe   <= '0;
         addr_pipe  <= '0;
         elem_pipe  <= '0;
         fail_count <= '0;
         fail_addr  <= '0;
         fail_elem  <= '0;
         fail_data  <= '0;
         pass       <= 1'b0;
      end else begin
         vld_pipe[0]  <= launch && (cur_op == OP_R);
         exp_pipe[0]  <= rexp;
         addr_pipe[0] <= addr;
         elem_pipe[0] <= elem;
         for (int s = 1; s <= STAGES; s++) begin
            vld_pipe[s]  <= vld_pipe[s-1];
            exp_pipe[s]  <= exp_pipe[s-1];
            addr_pipe[s] <= addr_pipe[s-1];
            elem_pipe[s] <= elem_pipe[s-1];
         end

         if (start_acc) begin
            // pipeline is empty in IDLE/DONE, so no compare is lost here
            fail_count <= '0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_data  <= '0;
            pass       <= 1'b0;
         end else begin
            fail_count <= cnt_nxt;
            // fail_count is zero exactly until the first mismatch
            if (mismatch && (fail_count == '0)) begin
               fail_addr <= addr_pipe[STAGES];
               fail_elem <= elem_pipe[STAGES];
               fail_data <= mem_q;
            end
            // last compare lands on the FLUSH edge; include it in pass
            if (state == S_FLUSH) pass <= (cnt_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: behavioural SRAM with injectable faults, directed runs,
// scoreboard of expected end-of-test results checked when done rises.
module tb_mbist_march_ctrl;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int N  = 1 << AW;
   localparam int DONE_LAT = 10 * N + 2;   // cyc at done-rise minus cyc before start edge

   typedef struct {
      logic        pass;
      int          cnt;
      int          addr;
      int          elem;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          mem_ceb, mem_web, busy, done, pass;
   logic [AW-1:0] mem_a, fail_addr;
   logic [DW-1:0] mem_d, fail_data;
   logic [DW-1:0] mem_q = '0;
   logic [7:0]    fail_count;
   logic [2:0]    fail_elem;

   logic          s_ceb, s_web, s_busy, s_done, s_pass;
   logic [AW-1:0] s_a, s_faddr;
   logic [DW-1:0] s_d, s_fdata;
   logic [5:0]    s_cnt;
   logic [2:0]    s_felem;

   int   n_chk = 0, n_pass = 0, cyc = 0, n_rd = 0, n_wr = 0, fault = 0;
   logic done_q = 1'b0;
   exp_t sb[$];
   exp_t mon_e;
   logic [DW-1:0] mem [N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(32'h0), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
      .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
      .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data));

   // Narrow counter, every read returns all-ones: 96 r0 fails must saturate at 63.
   mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(32'h0), .CNT_W(6)) dut_sat (
      .clk(clk), .rst(rst), .start(start),
      .mem_ceb(s_ceb), .mem_web(s_web), .mem_a(s_a), .mem_d(s_d), .mem_q({DW{1'b1}}),
      .busy(s_busy), .done(s_done), .pass(s_pass), .fail_count(s_cnt),
      .fail_addr(s_faddr), .fail_elem(s_felem), .fail_data(s_fdata));

   // SRAM model: 1 = bit0 of addr 7 stuck at 1, 2 = write to 3 inverts addr 4, 3 = all reads ones
   always @(posedge clk) begin
      if (!mem_ceb) begin
         if (!mem_web) begin
            mem[mem_a] <= mem_d;
            if (fault == 2 && mem_a == 5'd3) mem[4] <= ~mem[4];
         end else begin
            logic [DW-1:0] v;
            v = mem[mem_a];
            if (fault == 1 && mem_a == 5'd7) v[0] = 1'b1;
            if (fault == 3) v = '1;
            mem_q <= v;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!mem_ceb) begin
         if (mem_web) n_rd++;
         else n_wr++;
      end
      if (done && !done_q) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done at cyc %0d", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            chk("pass", 64'(pass), 64'(mon_e.pass));
            chk("fail_count", 64'(fail_count), 64'(mon_e.cnt));
            chk("fail_addr", 64'(fail_addr), 64'(mon_e.addr));
            chk("fail_elem", 64'(fail_elem), 64'(mon_e.elem));
            chk("fail_data", 64'(fail_data), 64'(mon_e.data));
            chk("busy_low_at_done", 64'(busy), 64'd0);
         end
      end
      done_q = done;
   end

   function automatic exp_t mk(input logic p, input int c, input int a, input int e,
                               input logic [31:0] d);
      exp_t r;
      r.pass = p; r.cnt = c; r.addr = a; r.elem = e; r.data = d; r.cyc = 0;
      return r;
   endfunction

   // Pulses start across one posedge (edge 0); returns on the negedge after it.
   task automatic do_start(input bit push, input exp_t e);
      @(negedge clk);
      start = 1'b1;
      e.cyc = cyc + DONE_LAT;
      if (push) sb.push_back(e);
      n_rd = 0;
      n_wr = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12 * N && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         n_chk++;
         $display("FAIL %s: timeout waiting for done", nm);
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_ceb"}, 64'(mem_ceb), 64'd1);
      chk({nm, "_web"}, 64'(mem_web), 64'd1);
      chk({nm, "_a"}, 64'(mem_a), 64'd0);
      chk({nm, "_d"}, 64'(mem_d), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd0);
      chk({nm, "_pass"}, 64'(pass), 64'd0);
      chk({nm, "_cnt"}, 64'(fail_count), 64'd0);
      chk({nm, "_faddr"}, 64'(fail_addr), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // 1: clean run, first ops on the pins, op mix
      do_start(1, mk(1, 0, 0, 0, 32'h0));
      chk("op1_ceb", 64'(mem_ceb), 64'd0);
      chk("op1_web", 64'(mem_web), 64'd0);
      chk("op1_a", 64'(mem_a), 64'd0);
      chk("busy_after_start", 64'(busy), 64'd1);
      @(negedge clk);
      chk("op2_a", 64'(mem_a), 64'd1);
      wait_done("clean");
      chk("clean_writes", 64'(n_wr), 64'(5 * N));
      chk("clean_reads", 64'(n_rd), 64'(5 * N));

      // 2: bit0 of addr 7 stuck at 1 -> fails on r0 in M1, M3, M5
      fault = 1;
      do_start(1, mk(0, 3, 7, 1, 32'h0000_0001));
      wait_done("stuck");

      // 3: write to addr 3 inverts addr 4 -> fails in M1 r0, M2 r1, M4 r1, M5 r0
      fault = 2;
      do_start(1, mk(0, 4, 4, 1, 32'hFFFF_FFFF));
      wait_done("coupling");

      // 4: every read all-ones -> 3N r0 fails
      fault = 3;
      do_start(1, mk(0, 3 * N, 0, 1, 32'hFFFF_FFFF));
      wait_done("all_ones");
      chk("sat_count", 64'(s_cnt), 64'h3F);
      chk("sat_pass", 64'(s_pass), 64'd0);
      chk("sat_faddr", 64'(s_faddr), 64'd0);
      chk("sat_felem", 64'(s_felem), 64'd1);

      // 5: start in DONE clears results on the start edge, then a clean rerun
      fault = 0;
      do_start(1, mk(1, 0, 0, 0, 32'h0));
      chk("restart_done_clr", 64'(done), 64'd0);
      chk("restart_pass_clr", 64'(pass), 64'd0);
      chk("restart_cnt_clr", 64'(fail_count), 64'd0);
      chk("restart_faddr_clr", 64'(fail_addr), 64'd0);
      chk("restart_felem_clr", 64'(fail_elem), 64'd0);
      chk("restart_fdata_clr", 64'(fail_data), 64'd0);
      wait_done("restart");

      // 6: start pulses while busy are ignored (done timing checked by monitor)
      do_start(1, mk(1, 0, 0, 0, 32'h0));
      repeat (8) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (189) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_done("start_while_busy");

      // 7: async reset mid-M2, checked before any further clock edge
      do_start(0, mk(1, 0, 0, 0, 32'h0));
      repeat (148) @(negedge clk);
      chk("pre_rst_ceb_active", 64'(mem_ceb), 64'd0);
      rst = 1'b1;
      #1;
      chk_reset_outputs("mid_rst");
      @(negedge clk);
      rst = 1'b0;

      // 8: clean run after the aborted one
      do_start(1, mk(1, 0, 0, 0, 32'h0));
      wait_done("after_rst");

      n_chk++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard_left: got %0d expected 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
